mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access stage that sits directly downstream of the third instruction pipeline register. It consumes the execute-stage instruction word, ALU result and store data. It performs loads and stores over a req/ack data-memory handshake and stalls the upstream pipeline while a transfer is in flight. It registers the write-back payload (data, rd, enable, instruction) for the write-back stage.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in BUSY without dmem_ack before a bus error is raised (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_in  input  32  instruction word from the third instruction buffer
in_valid  input  1  instr_in/alu_result/store_data hold a live instruction
alu_result  input  32  effective address (load/store) or result to write back
store_data  input  32  rs2 value for stores
dmem_req  output  1  memory request, held high until ack
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  32  byte address (alu_result captured at request)
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  read word, valid when dmem_ack = 1
dmem_ack  input  1  one-cycle completion pulse
stall_o  output  1  upstream must hold its registers and inputs
wb_valid  output  1  write-back payload valid
wb_en  output  1  register-file write enable
wb_rd  output  5  destination register
wb_data  output  32  write-back value
wb_instr  output  32  instruction forwarded to write-back
misalign_o  output  1  one-cycle pulse: misaligned access dropped
bus_err_o  output  1  one-cycle pulse: memory timeout

Behaviour:
- Reset: all outputs 0. State is IDLE and the timeout counter is 0. Async reset mid-transfer drops dmem_req immediately and abandons the access.
- Decode from instr_in:
  - opcode [6:0]: LOAD = 0000011, STORE = 0100011.
  - funct3 [14:12], rd [11:7].
  - Register-writing opcodes: LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR.
- Alignment:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 00.
  - Byte is always aligned.
- FSM with states IDLE and BUSY.
- IDLE, in_valid = 0: next cycle wb_valid = 0, wb_en = 0.
- IDLE, in_valid with non-memory op:
  - One-cycle latency: next edge wb_valid = 1, wb_data = alu_result, wb_rd = rd, wb_instr = instr_in.
  - wb_en = 1 only for register-writing opcodes with rd != 0.
  - stall_o stays 0.
- IDLE, in_valid with aligned LOAD/STORE:
  - stall_o = 1 combinationally in the same cycle.
  - Next edge: enter BUSY, dmem_req = 1, and register addr, we, be, wdata.
  - wb_valid = 0 for that cycle.
- IDLE, in_valid with misaligned LOAD/STORE:
  - No request is issued.
  - Next edge: misalign_o = 1 for one cycle, wb_valid = 1, wb_en = 0, wb_instr = instr_in.
  - No stall.
- BUSY:
  - dmem_req and all dmem_* signals are held stable.
  - stall_o = 1 while dmem_ack = 0, and stall_o = 0 in the ack cycle.
  - On ack: return to IDLE, dmem_req = 0, and the counter clears.
  - Load on ack: wb_data is the extended lane, with wb_en per rd != 0.
  - Store on ack: wb_en = 0, wb_valid = 1.
- Timeout: the counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES-1 with no ack, the next edge returns to IDLE with dmem_req = 0, bus_err_o pulses for one cycle, and wb_valid = 1, wb_en = 0.
  - A late ack arriving while in IDLE is ignored.
  - An ack arriving on the final counted cycle wins over the timeout.
- Load extension, lane selected by addr[1:0]:
  - LB (000) sign-extends the byte; LBU (100) zero-extends the byte.
  - LH (001) sign-extends the halfword at [addr1*16 +: 16]; LHU (101) zero-extends it.
  - LW (010) returns the full word.
  - Other funct3 values are treated as LW.
- Store encoding:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated ×4.
  - SH: be = 0011 << addr[1:0], wdata = half replicated ×2.
  - SW: be = 1111, wdata = store_data.
  - Loads drive be = 1111.
- Upstream contract: inputs are stable whenever stall_o = 1. The block never samples new inputs in BUSY.

Test Plan:
- Reset during BUSY: rst asserted while dmem_req = 1 → dmem_req drops the same cycle, all outputs 0. After release, an ADDI passes with one-cycle latency.
- ADDI x5, alu_result 0x0000_002A, in_valid → next cycle wb_valid = 1, wb_en = 1, wb_rd = 5, wb_data = 0x2A, stall_o = 0.
  - Same instruction with rd = 0 → wb_en = 0.
- LB at addr 0x1003, ack after 3 wait cycles, rdata = 0x80FF_1234 → stall_o high for 4 cycles, dmem_be = 1111. Then wb_data = 0xFFFF_FF80.
  - LBU at the same address → wb_data = 0x0000_0080.
- SH at addr 0x2002, store_data = 0x0000_BEEF → dmem_we = 1, be = 1100, wdata = 0xBEEF_BEEF. On ack, wb_en = 0 and wb_valid = 1.
- LW at addr 0x1001 → no dmem_req, misalign_o pulses for exactly one cycle, wb_en = 0, stall_o never asserted.
- LW with ack withheld, TIMEOUT_CYCLES = 16 → dmem_req high for exactly 16 cycles, then bus_err_o pulses and the stage returns to IDLE. A late ack 2 cycles later is ignored, giving no wb_valid.

Source files
------------

// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage fed by the third instruction pipeline register. Loads
// and stores are carried out over a req/ack data-memory handshake while the
// upstream pipeline is stalled. Every other instruction is forwarded to
// write-back with one cycle of latency.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without dmem_ack before a bus error (>= 2)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   instr_in        instruction word from the execute stage
//   in_valid        instr_in/alu_result/store_data carry a live instruction
//   alu_result      effective address (load/store) or result to write back
//   store_data      rs2 value for stores
//   dmem_req/we/addr/be/wdata   data-memory request, held stable until ack
//   dmem_rdata/ack  read data and one-cycle completion pulse
//   stall_o         upstream must hold its registers and inputs
//   wb_valid/en/rd/data/instr   registered write-back payload
//   misalign_o      one-cycle pulse: misaligned access dropped
//   bus_err_o       one-cycle pulse: memory timeout
// ----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_o,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_instr,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, next_state;

    // funct3[1:0]: 00 byte, 01 halfword, anything else behaves as a word.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a,
                                                input logic we);
        if (!we) return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Lanes are replicated so memory can pick whichever lane the enables select.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return 32'(b);
            3'b100:  return {24'h0, b};
            3'b001:  return 32'(h);
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_load, is_store, is_mem, aligned, writes_rd;

    assign opcode    = instr_in[6:0];
    assign funct3    = instr_in[14:12];
    assign rd        = instr_in[11:7];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_mem    = is_load | is_store;
    assign aligned   = addr_aligned(funct3, alu_result[1:0]);
    assign writes_rd = (opcode == OPC_LOAD)  | (opcode == OPC_OP)    |
                       (opcode == OPC_OPIMM) | (opcode == OPC_LUI)   |
                       (opcode == OPC_AUIPC) | (opcode == OPC_JAL)   |
                       (opcode == OPC_JALR);

    // Fields of the in-flight access, captured at request time.
    logic [2:0]       funct3_p1;
    logic [4:0]       rd_p1;
    logic [31:0]      instr_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic issue, pass, drop, done, expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall_o    = 1'b0;
        issue      = 1'b0;
        pass       = 1'b0;
        drop       = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        pass = 1'b1;
                    end else if (aligned) begin
                        issue      = 1'b1;
                        stall_o    = 1'b1;
                        next_state = BUSY;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack on the last counted cycle takes priority over the timeout.
                if (dmem_ack) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_p1 == CNT_LAST) begin
                        expire     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage boundary: request and write-back registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            funct3_p1  <= '0;
            rd_p1      <= '0;
            instr_p1   <= '0;
            cnt_p1     <= '0;
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_instr   <= '0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;

            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= alu_result;
                dmem_be    <= byte_enables(funct3, alu_result[1:0], is_store);
                dmem_wdata <= store_lanes(funct3, store_data);
                funct3_p1  <= funct3;
                rd_p1      <= rd;
                instr_p1   <= instr_in;
                cnt_p1     <= '0;
            end else if (pass || drop) begin
                wb_valid   <= 1'b1;
                wb_en      <= pass & writes_rd & (rd != 5'd0);
                wb_rd      <= rd;
                wb_data    <= alu_result;
                wb_instr   <= instr_in;
                misalign_o <= drop;
            end else if (done) begin
                dmem_req <= 1'b0;
                cnt_p1   <= '0;
                wb_valid <= 1'b1;
                wb_rd    <= rd_p1;
                wb_instr <= instr_p1;
                if (dmem_we) begin
                    wb_data <= dmem_addr;
                end else begin
                    wb_en   <= (rd_p1 != 5'd0);
                    wb_data <= load_extend(funct3_p1, dmem_addr[1:0], dmem_rdata);
                end
            end else if (expire) begin
                dmem_req  <= 1'b0;
                cnt_p1    <= '0;
                bus_err_o <= 1'b1;
                wb_valid  <= 1'b1;
                wb_rd     <= rd_p1;
                wb_data   <= '0;
                wb_instr  <= instr_p1;
            end else if (state == BUSY) begin
                cnt_p1 <= cnt_p1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage. Stimulus pushes the expected
// write-back record into a queue; an independent monitor pops and compares
// whenever wb_valid is seen. Handshake properties (stall length, request
// fields, timeout length) are checked inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_o;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_instr;
    logic        misalign_o;
    logic        bus_err_o;

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .in_valid   (in_valid),
        .alu_result (alu_result),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .stall_o    (stall_o),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_instr   (wb_instr),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] instr;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int req_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Running totals of stall/request cycles; tests compare deltas.
    always @(negedge clk) begin
        if (stall_o)  stall_cnt++;
        if (dmem_req) req_cnt++;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: wb_valid=1 instr=0x%0h, expected no output at %0t",
                             wb_instr, $time);
                end else begin
                    mon_e = q.pop_front();
                    check("wb_instr", 64'(wb_instr), 64'(mon_e.instr));
                    check("wb_en", 64'(wb_en), 64'(mon_e.en));
                    check("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
                    if (mon_e.chk_data) check("wb_data", 64'(wb_data), 64'(mon_e.data));
                    check("misalign_o", 64'(misalign_o), 64'(mon_e.mis));
                    check("bus_err_o", 64'(bus_err_o), 64'(mon_e.berr));
                end
            end else if (misalign_o || bus_err_o) begin
                checks++;
                errors++;
                $display("FAIL stray_flag: misalign=%0b bus_err=%0b without wb_valid at %0t",
                         misalign_o, bus_err_o, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [31:0] ins, input logic [31:0] alu, input logic exp_en);
        int s0;
        s0 = stall_cnt;
        instr_in   = ins;
        alu_result = alu;
        in_valid   = 1'b1;
        q.push_back('{en: exp_en, rd: ins[11:7], data: alu, chk_data: 1'b1,
                      instr: ins, mis: 1'b0, berr: 1'b0});
        step();
        in_valid = 1'b0;
        check("alu_stall", 64'(stall_cnt - s0), 64'd0);
    endtask

    task automatic mem_op(input logic [31:0] ins, input logic [31:0] addr,
                          input logic [31:0] sd, input int waitn,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic exp_en,
                          input logic [31:0] exp_data, input logic chk);
        int  s0, r0;
        logic exp_we;
        exp_we = (ins[6:0] == 7'b0100011);
        s0 = stall_cnt;
        r0 = req_cnt;
        instr_in   = ins;
        alu_result = addr;
        store_data = sd;
        in_valid   = 1'b1;
        q.push_back('{en: exp_en, rd: ins[11:7], data: exp_data, chk_data: chk,
                      instr: ins, mis: 1'b0, berr: 1'b0});
        step();
        check("req_up", 64'(dmem_req), 64'd1);
        check("req_we", 64'(dmem_we), 64'(exp_we));
        check("req_addr", 64'(dmem_addr), 64'(addr));
        check("req_be", 64'(dmem_be), 64'(exp_be));
        if (exp_we) check("req_wdata", 64'(dmem_wdata), 64'(exp_wd));
        repeat (waitn) step();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        check("mem_stall_cycles", 64'(stall_cnt - s0), 64'(waitn + 1));
        check("mem_req_cycles", 64'(req_cnt - r0), 64'(waitn + 1));
        check("req_down", 64'(dmem_req), 64'd0);
        step();
    endtask

    task automatic misaligned_op(input logic [31:0] ins, input logic [31:0] addr);
        int s0, r0;
        s0 = stall_cnt;
        r0 = req_cnt;
        instr_in   = ins;
        alu_result = addr;
        in_valid   = 1'b1;
        q.push_back('{en: 1'b0, rd: ins[11:7], data: addr, chk_data: 1'b0,
                      instr: ins, mis: 1'b1, berr: 1'b0});
        step();
        in_valid = 1'b0;
        check("mis_pulse", 64'(misalign_o), 64'd1);
        step();
        check("mis_one_cycle", 64'(misalign_o), 64'd0);
        check("mis_stall", 64'(stall_cnt - s0), 64'd0);
        check("mis_req", 64'(req_cnt - r0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst        = 1'b1;
        instr_in   = '0;
        in_valid   = 1'b0;
        alu_result = '0;
        store_data = '0;
        dmem_rdata = '0;
        dmem_ack   = 1'b0;
        #12;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_flags", 64'({wb_en, misalign_o, bus_err_o, dmem_we}), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Non-memory ops
        alu_op(32'h02A0_0293, 32'h0000_002A, 1'b1);  // ADDI x5
        alu_op(32'h02A0_0013, 32'h0000_002A, 1'b0);  // ADDI x0
        alu_op(32'h0000_04B7, 32'h1234_5000, 1'b1);  // LUI x9
        alu_op(32'h0000_0463, 32'h0000_0001, 1'b0);  // BEQ
        step();

        // Loads (rdata 0x80FF_1234)
        mem_op(32'h0000_0303, 32'h0000_1003, 32'h0, 3, 32'h80FF_1234, 4'hF, 32'h0,
               1'b1, 32'hFFFF_FF80, 1'b1);          // LB
        mem_op(32'h0000_4303, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 4'hF, 32'h0,
               1'b1, 32'h0000_0080, 1'b1);          // LBU
        mem_op(32'h0000_1303, 32'h0000_1002, 32'h0, 0, 32'h80FF_1234, 4'hF, 32'h0,
               1'b1, 32'hFFFF_80FF, 1'b1);          // LH
        mem_op(32'h0000_5303, 32'h0000_1002, 32'h0, 2, 32'h80FF_1234, 4'hF, 32'h0,
               1'b1, 32'h0000_80FF, 1'b1);          // LHU
        mem_op(32'h0000_2383, 32'h0000_1000, 32'h0, 0, 32'h80FF_1234, 4'hF, 32'h0,
               1'b1, 32'h80FF_1234, 1'b1);          // LW x7
        mem_op(32'h0000_2003, 32'h0000_1000, 32'h0, 0, 32'h80FF_1234, 4'hF, 32'h0,
               1'b0, 32'h80FF_1234, 1'b1);          // LW x0

        // Stores
        mem_op(32'h0000_10A3, 32'h0000_2002, 32'h0000_BEEF, 2, 32'h0, 4'b1100,
               32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0);   // SH
        mem_op(32'h0000_0023, 32'h0000_3001, 32'h0000_00A5, 0, 32'h0, 4'b0010,
               32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);   // SB
        mem_op(32'h0000_2023, 32'h0000_4000, 32'h1234_5678, 1, 32'h0, 4'b1111,
               32'h1234_5678, 1'b0, 32'h0, 1'b0);   // SW

        // Misaligned accesses
        misaligned_op(32'h0000_2383, 32'h0000_1001);  // LW
        misaligned_op(32'h0000_1303, 32'h0000_1003);  // LH

        // Timeout with a late ack
        r0 = req_cnt;
        instr_in   = 32'h0000_2383;
        alu_result = 32'h0000_5000;
        in_valid   = 1'b1;
        q.push_back('{en: 1'b0, rd: 5'd7, data: 32'h0, chk_data: 1'b0,
                      instr: 32'h0000_2383, mis: 1'b0, berr: 1'b1});
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_err_o) break;
        end
        in_valid = 1'b0;
        check("timeout_seen", 64'(bus_err_o), 64'd1);
        check("timeout_req_cycles", 64'(req_cnt - r0), 64'd16);
        check("timeout_req_down", 64'(dmem_req), 64'd0);
        step();
        check("timeout_one_cycle", 64'(bus_err_o), 64'd0);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        step();
        step();

        // Reset while a transfer is in flight
        instr_in   = 32'h0000_2383;
        alu_result = 32'h0000_6000;
        in_valid   = 1'b1;
        step();
        check("pre_rst_req", 64'(dmem_req), 64'd1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_req", 64'(dmem_req), 64'd0);
        check("midrst_addr", 64'(dmem_addr), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_wb", 64'({wb_valid, wb_en, misalign_o, bus_err_o}), 64'd0);
        step();
        rst = 1'b0;
        step();
        alu_op(32'h02A0_0293, 32'h0000_002A, 1'b1);  // ADDI x5 after reset
        step();
        step();

        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
